// File: rtl/mii_tx_arbiter.sv
// Two-source MII transmit arbiter. Grants whole frames round-robin onto one
// 64-bit MII lane. Each frame is wrapped with a START/preamble word and a
// TERMINATE, followed by an IDLE inter-frame gap.
// Optional feature: define MII_ARB_ERR_EN to turn beats flagged with terr
// into all-ERROR words. Without it the terr inputs are ignored.
module mii_tx_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,  // only 64 is supported
  parameter int unsigned IFG_CYCLES = 1    // IDLE words after each terminating word, >= 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s0_tdata,
  input  logic [DATA_WIDTH/8-1:0] s0_tkeep,
  input  logic                    s0_tvalid,
  input  logic                    s0_tlast,
  input  logic                    s0_terr,
  output logic                    s0_tready,
  input  logic [DATA_WIDTH-1:0]   s1_tdata,
  input  logic [DATA_WIDTH/8-1:0] s1_tkeep,
  input  logic                    s1_tvalid,
  input  logic                    s1_tlast,
  input  logic                    s1_terr,
  output logic                    s1_tready,
  output logic [DATA_WIDTH-1:0]   mii_txd,
  output logic [DATA_WIDTH/8-1:0] mii_txc,
  output logic                    busy,
  output logic                    active_src,
  output logic [31:0]             tx_frames,
  output logic [15:0]             underrun_cnt
);

  localparam int unsigned CtrlW = DATA_WIDTH / 8;

  localparam logic [7:0] CodeIdle  = 8'h07;
  localparam logic [7:0] CodeStart = 8'hFB;
  localparam logic [7:0] CodeTerm  = 8'hFD;
  localparam logic [7:0] CodeError = 8'hFE;
  localparam logic [7:0] CodePre   = 8'h55;
  localparam logic [7:0] CodeSfd   = 8'hD5;

  localparam logic [DATA_WIDTH-1:0] IdleWord  = {CtrlW{CodeIdle}};
  localparam logic [DATA_WIDTH-1:0] ErrorWord = {CtrlW{CodeError}};
  localparam logic [DATA_WIDTH-1:0] PreWord   = {CodeSfd, {(CtrlW-2){CodePre}}, CodeStart};
  localparam logic [DATA_WIDTH-1:0] TermWord  = {{(CtrlW-1){CodeIdle}}, CodeTerm};
  localparam logic [CtrlW-1:0]      PreCtrl   = {{(CtrlW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StPayload,
    StTerm,
    StIfg
  } state_e;

  state_e          state_q;
  logic [31:0]     ifg_cnt_q;

  logic [DATA_WIDTH-1:0] sel_tdata;
  logic [CtrlW-1:0]      sel_tkeep;
  logic                  sel_tvalid;
  logic                  sel_tlast;
  logic                  beat_err;
  logic                  grant_next;
  logic                  full_keep;
  logic [3:0]            n_keep;
  logic [DATA_WIDTH-1:0] tail_txd;
  logic [CtrlW-1:0]      tail_txc;

  function automatic logic [3:0] popcount(input logic [CtrlW-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < CtrlW; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Route the granted source's beat to the datapath.
  always_comb begin
    sel_tdata  = s0_tdata;
    sel_tkeep  = s0_tkeep;
    sel_tvalid = s0_tvalid;
    sel_tlast  = s0_tlast;
    if (active_src) begin
      sel_tdata  = s1_tdata;
      sel_tkeep  = s1_tkeep;
      sel_tvalid = s1_tvalid;
      sel_tlast  = s1_tlast;
    end
  end

`ifdef MII_ARB_ERR_EN
  assign beat_err = active_src ? s1_terr : s0_terr;
`else
  logic unused_terr;
  assign unused_terr = s0_terr ^ s1_terr;
  assign beat_err    = 1'b0;
`endif

  // On contention the source that did not go last wins; otherwise whoever asks.
  assign grant_next = (s0_tvalid && s1_tvalid) ? ~active_src : s1_tvalid;

  assign full_keep = &sel_tkeep;

  // Short last beat: data lanes, one TERM lane, IDLE padding above it.
  always_comb begin
    n_keep   = popcount(sel_tkeep);
    tail_txd = IdleWord;
    for (int i = 0; i < CtrlW; i++) begin
      if (i < int'(n_keep)) begin
        tail_txd[8*i +: 8] = sel_tdata[8*i +: 8];
      end else if (i == int'(n_keep)) begin
        tail_txd[8*i +: 8] = CodeTerm;
      end
    end
  end

  assign tail_txc = ~sel_tkeep;

  // Ready only for the granted source while the payload is flowing; held low in reset
  // so no beat is consumed from a frame that reset is about to abandon.
  always_comb begin
    s0_tready = (state_q == StPayload) && !active_src && !rst;
    s1_tready = (state_q == StPayload) &&  active_src && !rst;
  end

  assign busy = (state_q != StIdle);

  // Frame sequencing FSM with registered MII outputs and statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ifg_cnt_q    <= '0;
      mii_txd      <= IdleWord;
      mii_txc      <= '1;
      active_src   <= 1'b1;
      tx_frames    <= '0;
      underrun_cnt <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          mii_txd <= IdleWord;
          mii_txc <= '1;
          if (s0_tvalid || s1_tvalid) begin
            active_src <= grant_next;
            state_q    <= StPreamble;
          end
        end

        StPreamble: begin
          mii_txd <= PreWord;
          mii_txc <= PreCtrl;
          state_q <= StPayload;
        end

        StPayload: begin
          if (!sel_tvalid) begin
            // Source starved mid-frame: poison the word, keep waiting for it.
            mii_txd <= ErrorWord;
            mii_txc <= '1;
            if (underrun_cnt != 16'hFFFF) begin
              underrun_cnt <= underrun_cnt + 16'd1;
            end
          end else if (beat_err) begin
            mii_txd <= ErrorWord;
            mii_txc <= '1;
            if (sel_tlast) begin
              state_q <= StTerm;
            end
          end else if (!sel_tlast) begin
            mii_txd <= sel_tdata;
            mii_txc <= '0;
          end else if (full_keep) begin
            // No free lane for TERM, so it goes out in its own word.
            mii_txd <= sel_tdata;
            mii_txc <= '0;
            state_q <= StTerm;
          end else begin
            mii_txd   <= tail_txd;
            mii_txc   <= tail_txc;
            tx_frames <= tx_frames + 32'd1;
            ifg_cnt_q <= '0;
            state_q   <= StIfg;
          end
        end

        StTerm: begin
          mii_txd   <= TermWord;
          mii_txc   <= '1;
          tx_frames <= tx_frames + 32'd1;
          ifg_cnt_q <= '0;
          state_q   <= StIfg;
        end

        StIfg: begin
          mii_txd <= IdleWord;
          mii_txc <= '1;
          if (ifg_cnt_q == IFG_CYCLES - 32'd1) begin
            state_q <= StIdle;
          end else begin
            ifg_cnt_q <= ifg_cnt_q + 32'd1;
          end
        end

        default: begin
          mii_txd <= IdleWord;
          mii_txc <= '1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Self-checking bench for mii_tx_arbiter: directed scenarios plus random frames,
// checked against a frame-level model of the expected MII word stream.
module tb_mii_tx_arbiter;

  localparam int unsigned IFG = 1;
  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W = 64'h07070707070707FD;
`ifdef MII_ARB_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s0_tdata, s1_tdata;
  logic [7:0]  s0_tkeep, s1_tkeep;
  logic        s0_tvalid, s1_tvalid, s0_tlast, s1_tlast, s0_terr, s1_terr;
  logic        s0_tready, s1_tready;
  logic [63:0] mii_txd;
  logic [7:0]  mii_txc;
  logic        busy, active_src;
  logic [31:0] tx_frames;
  logic [15:0] underrun_cnt;

  always #5 clk = ~clk;

  mii_tx_arbiter #(.DATA_WIDTH(64), .IFG_CYCLES(IFG)) dut (
    .clk(clk), .rst(rst),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast),
    .s0_terr(s0_terr), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast),
    .s1_terr(s1_terr), .s1_tready(s1_tready),
    .mii_txd(mii_txd), .mii_txc(mii_txc), .busy(busy), .active_src(active_src),
    .tx_frames(tx_frames), .underrun_cnt(underrun_cnt)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        err;
    logic        first;
    int          gap;  // cycles valid stays low before this beat
  } beat_t;

  beat_t       drv0[$], drv1[$];
  beat_t       mdl0[$], mdl1[$];
  logic [71:0] exp_q[$];
  int          pend0, pend1, gap0, gap1;
  int          n_pass, n_checks, n_fail;
  int          frames_done, exp_under, idle_run;
  bit          prev_end, cur_src, last_grant;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] tail_word(input logic [63:0] d, input logic [7:0] k);
    int          n = 0;
    logic [63:0] w;
    logic [7:0]  c;
    for (int i = 0; i < 8; i++) if (k[i]) n++;
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        w[8*i +: 8] = d[8*i +: 8];
        c[i] = 1'b0;
      end else if (i == n) begin
        w[8*i +: 8] = 8'hFD;
        c[i] = 1'b1;
      end else begin
        w[8*i +: 8] = 8'h07;
        c[i] = 1'b1;
      end
    end
    return {c, w};
  endfunction

  task automatic add_frame(input bit src, input int len, input int nlast, input int gap_at,
                           input int gap_len, input int err_at, input bit rnd_keep);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data  = {$urandom, $urandom};
      b.first = (i == 0);
      b.last  = (i == len - 1);
      b.err   = (i == err_at);
      b.gap   = (i == gap_at && i > 0) ? gap_len : 0;
      if (b.last) b.keep = 8'hFF >> (8 - nlast);
      else        b.keep = rnd_keep ? 8'($urandom) : 8'hFF;
      exp_under += b.gap;
      if (src) begin drv1.push_back(b); mdl1.push_back(b); end
      else     begin drv0.push_back(b); mdl0.push_back(b); end
    end
    if (src) pend1++; else pend0++;
  endtask

  // Expand one frame of the granted source into the MII words it must produce.
  task automatic gen_expected(input bit src);
    beat_t b;
    bit    done = 1'b0;
    while (!done) begin
      if (src) b = mdl1.pop_front(); else b = mdl0.pop_front();
      if (!b.first) repeat (b.gap) exp_q.push_back({8'hFF, ERR_W});
      if (ErrEn && b.err) begin
        exp_q.push_back({8'hFF, ERR_W});
        if (b.last) exp_q.push_back({8'hFF, TERM_W});
      end else if (!b.last) begin
        exp_q.push_back({8'h00, b.data});
      end else if (b.keep == 8'hFF) begin
        exp_q.push_back({8'h00, b.data});
        exp_q.push_back({8'hFF, TERM_W});
      end else begin
        exp_q.push_back(tail_word(b.data, b.keep));
      end
      done = b.last;
    end
  endtask

  task automatic drive();
    if (drv0.size() > 0 && gap0 == 0) begin
      s0_tvalid = 1'b1; s0_tdata = drv0[0].data; s0_tkeep = drv0[0].keep;
      s0_tlast = drv0[0].last; s0_terr = drv0[0].err;
    end else begin
      s0_tvalid = 1'b0; s0_tdata = {$urandom, $urandom}; s0_tkeep = 8'($urandom);
      s0_tlast = 1'($urandom); s0_terr = 1'($urandom);
    end
    if (drv1.size() > 0 && gap1 == 0) begin
      s1_tvalid = 1'b1; s1_tdata = drv1[0].data; s1_tkeep = drv1[0].keep;
      s1_tlast = drv1[0].last; s1_terr = drv1[0].err;
    end else begin
      s1_tvalid = 1'b0; s1_tdata = {$urandom, $urandom}; s1_tkeep = 8'($urandom);
      s1_tlast = 1'($urandom); s1_terr = 1'($urandom);
    end
  endtask

  task automatic drv_step(input bit acc0, input bit acc1);
    if (acc0) begin
      drv0.delete(0);
      gap0 = (drv0.size() > 0 && !drv0[0].first) ? drv0[0].gap : 0;
    end else if (gap0 > 0) gap0--;
    if (acc1) begin
      drv1.delete(0);
      gap1 = (drv1.size() > 0 && !drv1[0].first) ? drv1[0].gap : 0;
    end else if (gap1 > 0) gap1--;
    drive();
  endtask

  task automatic check_cycle();
    logic [71:0] obs;
    logic [71:0] e;
    bit          src;
    obs = {mii_txc, mii_txd};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("frame_word", obs, e);
      chk("other_tready_low", 72'(cur_src ? s0_tready : s1_tready), 72'(0));
      if (exp_q.size() == 0) begin
        frames_done++;
        chk("tx_frames", 72'(tx_frames), 72'(frames_done));
        prev_end = 1'b1;
        idle_run = 0;
      end
    end else if (obs === {8'h01, PRE_W} && (pend0 + pend1) > 0) begin
      if (pend0 > 0 && pend1 > 0) src = ~last_grant;
      else                        src = (pend1 > 0);
      chk("grant_src", 72'(active_src), 72'(src));
      chk("busy_in_frame", 72'(busy), 72'(1));
      if (prev_end) chk("ifg_len", 72'(idle_run), 72'(IFG + 1));
      last_grant = src;
      cur_src    = src;
      if (src) pend1--; else pend0--;
      gen_expected(src);
    end else begin
      chk("idle_word", obs, {8'hFF, IDLE_W});
      chk("tready_idle", 72'({s0_tready, s1_tready}), 72'(0));
      idle_run++;
    end
  endtask

  task automatic run_traffic(input int max_cyc);
    int idle_tail = 0;
    bit a0, a1;
    prev_end = 1'b0;
    idle_run = 0;
    drive();
    for (int c = 0; c < max_cyc && idle_tail < int'(IFG) + 3; c++) begin
      @(negedge clk);
      check_cycle();
      a0 = s0_tvalid && s0_tready;
      a1 = s1_tvalid && s1_tready;
      @(posedge clk); #1;
      drv_step(a0, a1);
      if (drv0.size() == 0 && drv1.size() == 0 && exp_q.size() == 0 && pend0 == 0 && pend1 == 0)
        idle_tail++;
      else
        idle_tail = 0;
    end
    chk("traffic_drained",
        72'(exp_q.size() + pend0 + pend1 + drv0.size() + drv1.size()), 72'(0));
    chk("underrun_cnt", 72'(underrun_cnt), 72'(exp_under));
  endtask

  task automatic do_reset();
    drv0.delete(); drv1.delete(); mdl0.delete(); mdl1.delete(); exp_q.delete();
    pend0 = 0; pend1 = 0; gap0 = 0; gap1 = 0;
    frames_done = 0; exp_under = 0; last_grant = 1'b1; prev_end = 1'b0; idle_run = 0;
    rst = 1'b1;
    drive();
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  initial begin
    int      acc;
    int      nf, len, nl, ga, gl, ea;
    logic [31:0] saved;
    n_pass = 0; n_checks = 0; n_fail = 0;

    // Reset state, then a quiet line for 20 cycles.
    do_reset();
    @(negedge clk);
    chk("rst_word", {mii_txc, mii_txd}, {8'hFF, IDLE_W});
    chk("rst_active_src", 72'(active_src), 72'(1));
    chk("rst_tx_frames", 72'(tx_frames), 72'(0));
    chk("rst_underrun", 72'(underrun_cnt), 72'(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("quiet_word", {mii_txc, mii_txd}, {8'hFF, IDLE_W});
      chk("quiet_tready", 72'({s0_tready, s1_tready}), 72'(0));
      chk("quiet_busy", 72'(busy), 72'(0));
    end

    // s0 3-beat frame ending with 4 valid bytes.
    add_frame(1'b0, 3, 4, -1, 0, -1, 1'b0);
    run_traffic(200);

    // s0 2-beat frame with a full last beat: TERM in its own word.
    add_frame(1'b0, 2, 8, -1, 0, -1, 1'b0);
    run_traffic(200);

    // Both sources contending with single-beat frames: grants must alternate.
    for (int i = 0; i < 3; i++) begin
      add_frame(1'b0, 1, 1 + i, -1, 0, -1, 1'b0);
      add_frame(1'b1, 1, 8 - i, -1, 0, -1, 1'b0);
    end
    run_traffic(400);

    // Two-cycle underrun in the middle of a frame.
    add_frame(1'b0, 3, 5, 2, 2, -1, 1'b0);
    run_traffic(200);

    // Corrupt flag on the second of three beats.
    add_frame(1'b0, 3, 6, -1, 0, 1, 1'b0);
    run_traffic(200);

    // Random traffic on both sources.
    for (int s = 0; s < 2; s++) begin
      nf = 8 + s;
      for (int f = 0; f < nf; f++) begin
        len = int'($urandom_range(1, 5));
        nl  = int'($urandom_range(1, 8));
        ga  = (len > 1) ? int'($urandom_range(1, len - 1)) : -1;
        gl  = int'($urandom_range(0, 3));
        ea  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
        add_frame(1'(s), len, nl, ga, gl, ea, 1'b1);
      end
    end
    run_traffic(3000);

    // Reset in the middle of a payload abandons the frame.
    saved     = tx_frames;
    s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tkeep = 8'hFF; s0_terr = 1'b0;
    s0_tdata  = {$urandom, $urandom};
    acc = 0;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      @(negedge clk);
      if (s0_tvalid && s0_tready) acc++;
      @(posedge clk); #1;
      s0_tdata = {$urandom, $urandom};
    end
    chk("midrst_beats_accepted", 72'(acc), 72'(2));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_frames_held", 72'(tx_frames), 72'(saved));
    @(posedge clk); #1;
    rst = 1'b0;
    s0_tvalid = 1'b0;
    @(negedge clk);
    chk("midrst_word", {mii_txc, mii_txd}, {8'hFF, IDLE_W});
    chk("midrst_tready", 72'({s0_tready, s1_tready}), 72'(0));
    chk("midrst_busy", 72'(busy), 72'(0));
    chk("midrst_frames_zero", 72'(tx_frames), 72'(0));
    chk("midrst_underrun_zero", 72'(underrun_cnt), 72'(0));
    chk("midrst_active_src", 72'(active_src), 72'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
